// File: rtl/c3lib_vecsync_qual.sv
// Qualifies a synchronized vector: a new value is forwarded only after it has been
// sampled unchanged STABLE_CYCLES times; each accepted change strobes and updates masks/count.
module c3lib_vecsync_qual #(
  parameter int DWIDTH        = 8,
  parameter int RESET_VAL     = 0,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DWIDTH-1:0]    data_in,
  input  logic                 cnt_clr,
  output logic [DWIDTH-1:0]    data_out,
  output logic                 upd_pulse,
  output logic [DWIDTH-1:0]    rise_mask,
  output logic [DWIDTH-1:0]    fall_mask,
  output logic [CNT_WIDTH-1:0] chg_cnt,
  output logic                 busy
);

  localparam int SCW = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [SCW-1:0]    STAB_ONE  = SCW'(1);
  localparam logic [SCW-1:0]    STAB_LAST = SCW'(STABLE_CYCLES - 1);
  localparam logic [DWIDTH-1:0] RST_VEC   = (RESET_VAL == 0) ? {DWIDTH{1'b0}} : {DWIDTH{1'b1}};

  typedef enum logic {IDLE, QUAL} state_t;

  state_t                state_q, state_d;
  logic [DWIDTH-1:0]     cand_q, cand_d;
  logic [SCW-1:0]        stab_cnt_q, stab_cnt_d;
  logic [DWIDTH-1:0]     data_out_q, data_out_d;
  logic                  upd_pulse_q, upd_pulse_d;
  logic [DWIDTH-1:0]     rise_mask_q, rise_mask_d;
  logic [DWIDTH-1:0]     fall_mask_q, fall_mask_d;
  logic [CNT_WIDTH-1:0]  chg_cnt_q, chg_cnt_d;
  logic                  commit;
  logic [DWIDTH-1:0]     commit_val;

  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    stab_cnt_d = stab_cnt_q;
    commit     = 1'b0;
    commit_val = data_in;
    case (state_q)
      IDLE: begin
        if (data_in != data_out_q) begin
          if (STABLE_CYCLES == 1) begin
            commit = 1'b1;
          end else begin
            cand_d     = data_in;
            stab_cnt_d = STAB_ONE;
            state_d    = QUAL;
          end
        end
      end
      QUAL: begin
        if (data_in == cand_q) begin
          if (stab_cnt_q == STAB_LAST) begin
            commit     = 1'b1;
            commit_val = cand_q;
            state_d    = IDLE;
          end else begin
            stab_cnt_d = stab_cnt_q + STAB_ONE;
          end
        end else if (data_in == data_out_q) begin
          // transient code collapsed back to the held value: drop it silently
          state_d = IDLE;
        end else begin
          cand_d     = data_in;
          stab_cnt_d = STAB_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_out_d  = data_out_q;
    upd_pulse_d = commit;
    rise_mask_d = rise_mask_q;
    fall_mask_d = fall_mask_q;
    chg_cnt_d   = chg_cnt_q;
    if (commit) begin
      data_out_d  = commit_val;
      rise_mask_d = commit_val & ~data_out_q;
      fall_mask_d = ~commit_val & data_out_q;
      if (chg_cnt_q != {CNT_WIDTH{1'b1}}) chg_cnt_d = chg_cnt_q + CNT_WIDTH'(1);
    end
    // a clear that lands on a commit still counts that commit
    if (cnt_clr) chg_cnt_d = commit ? CNT_WIDTH'(1) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cand_q      <= RST_VEC;
      stab_cnt_q  <= '0;
      data_out_q  <= RST_VEC;
      upd_pulse_q <= 1'b0;
      rise_mask_q <= '0;
      fall_mask_q <= '0;
      chg_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      stab_cnt_q  <= stab_cnt_d;
      data_out_q  <= data_out_d;
      upd_pulse_q <= upd_pulse_d;
      rise_mask_q <= rise_mask_d;
      fall_mask_q <= fall_mask_d;
      chg_cnt_q   <= chg_cnt_d;
    end
  end

  assign data_out  = data_out_q;
  assign upd_pulse = upd_pulse_q;
  assign rise_mask = rise_mask_q;
  assign fall_mask = fall_mask_q;
  assign chg_cnt   = chg_cnt_q;
  assign busy      = (state_q == QUAL);

endmodule

// File: tb/tb_c3lib_vecsync_qual.sv
// Bench for c3lib_vecsync_qual: two instances (4-sample/2-bit-count/reset-high and
// 1-sample/8-bit-count/reset-low) checked every cycle against a run-length reference model.
module tb_c3lib_vecsync_qual;

  logic       clk;
  logic       rst_n;
  logic       cnt_clr;
  logic [7:0] a_in, b_in;

  logic [7:0] a_dout, a_rise, a_fall, b_dout, b_rise, b_fall;
  logic       a_upd, a_busy, b_upd, b_busy;
  logic [1:0] a_cnt;
  logic [7:0] b_cnt;

  int ncmp = 0;
  int nerr = 0;

  c3lib_vecsync_qual #(.DWIDTH(8), .RESET_VAL(1), .STABLE_CYCLES(4), .CNT_WIDTH(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .data_in(a_in), .cnt_clr(cnt_clr),
    .data_out(a_dout), .upd_pulse(a_upd), .rise_mask(a_rise), .fall_mask(a_fall),
    .chg_cnt(a_cnt), .busy(a_busy)
  );

  c3lib_vecsync_qual #(.DWIDTH(8), .RESET_VAL(0), .STABLE_CYCLES(1), .CNT_WIDTH(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .data_in(b_in), .cnt_clr(cnt_clr),
    .data_out(b_dout), .upd_pulse(b_upd), .rise_mask(b_rise), .fall_mask(b_fall),
    .chg_cnt(b_cnt), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a value is accepted once the current run of identical samples
  // reaches the required length and differs from the accepted value.
  int         req_len [2] = '{4, 1};
  int         cnt_max [2] = '{3, 255};
  logic [7:0] rst_val [2] = '{8'hFF, 8'h00};
  logic [7:0] m_dout [2], m_last [2], m_rise [2], m_fall [2];
  int         m_run [2], m_cnt [2];
  logic       m_upd [2], m_busy [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_dout[i] = rst_val[i]; m_last[i] = 8'h00; m_rise[i] = 8'h00; m_fall[i] = 8'h00;
      m_run[i]  = 0; m_cnt[i] = 0; m_upd[i] = 1'b0; m_busy[i] = 1'b0;
    end
  endtask

  task automatic model_step(input int i, input logic [7:0] din, input logic clr);
    bit commit;
    if (m_run[i] > 0 && din == m_last[i]) begin
      if (m_run[i] < 1000) m_run[i]++;
    end else begin
      m_run[i] = 1;
    end
    m_last[i] = din;
    commit = (din != m_dout[i]) && (m_run[i] >= req_len[i]);
    m_upd[i] = commit;
    if (commit) begin
      m_rise[i] = din & ~m_dout[i];
      m_fall[i] = ~din & m_dout[i];
      m_dout[i] = din;
    end
    if (clr) m_cnt[i] = commit ? 1 : 0;
    else if (commit && m_cnt[i] < cnt_max[i]) m_cnt[i]++;
    m_busy[i] = (din != m_dout[i]);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a_data_out", 32'(a_dout), 32'(m_dout[0]));
    chk("a_upd",      32'(a_upd),  32'(m_upd[0]));
    chk("a_rise",     32'(a_rise), 32'(m_rise[0]));
    chk("a_fall",     32'(a_fall), 32'(m_fall[0]));
    chk("a_chg_cnt",  32'(a_cnt),  32'(m_cnt[0]));
    chk("a_busy",     32'(a_busy), 32'(m_busy[0]));
    chk("b_data_out", 32'(b_dout), 32'(m_dout[1]));
    chk("b_upd",      32'(b_upd),  32'(m_upd[1]));
    chk("b_rise",     32'(b_rise), 32'(m_rise[1]));
    chk("b_fall",     32'(b_fall), 32'(m_fall[1]));
    chk("b_chg_cnt",  32'(b_cnt),  32'(m_cnt[1]));
    chk("b_busy",     32'(b_busy), 32'(m_busy[1]));
  endtask

  task automatic step(input logic [7:0] a, input logic [7:0] b, input logic clr);
    a_in = a; b_in = b; cnt_clr = clr;
    @(posedge clk);
    model_step(0, a, clr);
    model_step(1, b, clr);
    #1;
    check_all();
  endtask

  task automatic hold(input logic [7:0] v, input int n);
    for (int k = 0; k < n; k++) step(v, v, 1'b0);
  endtask

  logic [7:0] pool [4] = '{8'h00, 8'h3C, 8'hFF, 8'h81};
  logic [7:0] v, bv;
  int         len;

  initial begin
    rst_n = 1'b0; cnt_clr = 1'b0; a_in = 8'h00; b_in = 8'h00;
    model_reset();
    #12;
    check_all();
    chk("reset_a_dout_ff", 32'(a_dout), 32'h0000_00FF);
    @(negedge clk);
    rst_n = 1'b1;

    hold(8'h00, 5);
    // 0x5A held: busy after E0, commit visible after E0+3
    step(8'h5A, 8'h5A, 1'b0);
    chk("qual_busy_e0", 32'(a_busy), 32'h1);
    hold(8'h5A, 2);
    chk("qual_no_early", 32'(a_upd), 32'h0);
    step(8'h5A, 8'h5A, 1'b0);
    chk("qual_commit_5a", 32'(a_dout), 32'h5A);
    chk("qual_rise_5a", 32'(a_rise), 32'h5A);
    hold(8'h5A, 2);

    // glitch of two samples
    hold(8'h7F, 2);
    hold(8'h5A, 4);
    chk("glitch_dout", 32'(a_dout), 32'h5A);

    // candidate restart
    hold(8'h00, 5);
    hold(8'h01, 2);
    hold(8'h03, 5);
    chk("restart_rise", 32'(a_rise), 32'h03);
    chk("sat_cnt", 32'(a_cnt), 32'h3);

    // clear coinciding with a commit, then a plain clear
    hold(8'h0F, 3);
    step(8'h0F, 8'h0F, 1'b1);
    chk("clr_commit_cnt", 32'(a_cnt), 32'h1);
    step(8'h0F, 8'h0F, 1'b1);
    hold(8'h0F, 2);

    // reset during qualification of 0xAA
    hold(8'hAA, 2);
    rst_n = 1'b0;
    #2;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    hold(8'hAA, 3);
    chk("postrst_no_early", 32'(a_dout), 32'hFF);
    hold(8'hAA, 2);
    chk("postrst_commit", 32'(a_dout), 32'hAA);

    // randomized runs drawn from a small value pool so glitches return to the held value
    bv = 8'h00;
    for (int r = 0; r < 120; r++) begin
      v   = pool[$urandom_range(0, 3)];
      len = $urandom_range(1, 6);
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 1) == 1) bv = 8'($urandom);
        step(v, bv, ($urandom_range(0, 15) == 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
